// File: rtl/mips_pkg.sv
// Shared MIPS core types and widths used by the pipeline stages.
// Holds no logic: no latency, no backpressure.
package mips_pkg;

  localparam int WORD_W     = 32;
  localparam int REG_ADDR_W = 5;

  // Writeback control bits carried from MEM into WB.
  typedef struct packed {
    logic memToReg;
    logic regWrite;
  } wb_ctrl_t;

endpackage

// File: rtl/data_memory.sv
// Word-addressed data RAM: asynchronous read, write committed at the clock edge.
// Read is 0-cycle, write lands at the next edge; no backpressure, reset blocks writes.
module data_memory
  import mips_pkg::*;
#(
  parameter int ADDR_BITS = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              memRead,
  input  logic              memWrite,
  input  logic [WORD_W-1:0] address,
  input  logic [WORD_W-1:0] writeData,
  output logic [WORD_W-1:0] readData
);

  logic [WORD_W-1:0]    mem [2**ADDR_BITS];
  logic [ADDR_BITS-1:0] index;

  // Byte offset and high address bits are dropped: no alignment traps, addresses wrap.
  assign index = address[ADDR_BITS+1:2];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{address[1:0], address[WORD_W-1:ADDR_BITS+2]};

  assign readData = memRead ? mem[index] : '0;

  always_ff @(posedge clk) begin
    if (!reset && memWrite) begin
      mem[index] <= writeData;
    end
  end

endmodule

// File: rtl/memory_access.sv
// MEM pipeline stage with data-memory access, MEM/WB register and writeback mux.
// Forwarding taps are 0-cycle, WB outputs 1 cycle; no stall/backpressure, updates every edge.
module memory_access
  import mips_pkg::*;
#(
  parameter int ADDR_BITS = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  memToRegMemInput,
  input  logic                  regWriteMemInput,
  input  logic                  memWriteMemInput,
  input  logic                  memReadMemInput,
  input  logic [WORD_W-1:0]     aluResultMemInput,
  input  logic [WORD_W-1:0]     memWriteDataMemInput,
  input  logic [REG_ADDR_W-1:0] regWriteRegisterMemInput,
  output logic [WORD_W-1:0]     aluResultMem,
  output logic                  regWriteMem,
  output logic [REG_ADDR_W-1:0] regWriteRegisterMem,
  output logic                  memToRegWb,
  output logic                  regWriteWb,
  output logic [REG_ADDR_W-1:0] writeRegisterWb,
  output logic [WORD_W-1:0]     readDataWb,
  output logic [WORD_W-1:0]     aluResultWb,
  output logic [WORD_W-1:0]     regWriteDataWb
);

  logic [WORD_W-1:0]     read_data_raw;
  wb_ctrl_t              wb_ctrl;
  logic [REG_ADDR_W-1:0] wb_reg;
  logic [WORD_W-1:0]     wb_read_data;
  logic [WORD_W-1:0]     wb_alu_result;

  data_memory #(
    .ADDR_BITS(ADDR_BITS)
  ) u_data_memory (
    .clk      (clk),
    .reset    (reset),
    .memRead  (memReadMemInput),
    .memWrite (memWriteMemInput),
    .address  (aluResultMemInput),
    .writeData(memWriteDataMemInput),
    .readData (read_data_raw)
  );

  assign aluResultMem        = aluResultMemInput;
  assign regWriteMem         = regWriteMemInput;
  assign regWriteRegisterMem = regWriteRegisterMemInput;

  always_ff @(posedge clk) begin
    if (reset) begin
      wb_ctrl       <= '0;
      wb_reg        <= '0;
      wb_read_data  <= '0;
      wb_alu_result <= '0;
    end else begin
      wb_ctrl.memToReg <= memToRegMemInput;
      wb_ctrl.regWrite <= regWriteMemInput;
      wb_reg           <= regWriteRegisterMemInput;
      wb_read_data     <= read_data_raw;
      wb_alu_result    <= aluResultMemInput;
    end
  end

  assign memToRegWb      = wb_ctrl.memToReg;
  assign regWriteWb      = wb_ctrl.regWrite;
  assign writeRegisterWb = wb_reg;
  assign readDataWb      = wb_read_data;
  assign aluResultWb     = wb_alu_result;
  assign regWriteDataWb  = wb_ctrl.memToReg ? wb_read_data : wb_alu_result;

endmodule
